// File: rtl/display_pkg.sv
// Shared segment types and the hex-to-segment table for the display scan driver.
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex value.
  localparam seg_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex digit to active-low seven-segment pattern.
module hex_seg_decode
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/display_scan_driver.sv
// Multiplexed common-anode seven-segment driver with frame latching,
// per-digit blank/blink and PWM brightness.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int PWM_BITS     = 3,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    display_On,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [6:0]              cathode,
  output logic                    svn_Seg_Dot,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_tick
);

  localparam int SLOT   = REFRESH_DIV >> PWM_BITS;
  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SLOT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int BL_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [REF_W-1:0]  REF_TC    = REF_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LOAD = SLOT_W'(SLOT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BL_W-1:0]   BLINK_TC  = BL_W'(BLINK_FRAMES - 1);
  localparam bit                NO_GUARD_DIV = (REFRESH_DIV == (1 << PWM_BITS));

  logic [REF_W-1:0]        refresh_cnt;
  logic [SLOT_W-1:0]       slot_cnt;
  logic [PWM_BITS-1:0]     sub_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [BL_W-1:0]         blink_cnt;
  logic                    blink_off;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [NUM_DIGITS-1:0]   shadow_blink;

  logic                  refresh_tc;
  logic                  frame_wrap;
  logic                  pwm_on;
  logic                  visible;
  logic                  ghost_guard;
  logic [3:0]            cur_hex;
  seg_t                  cur_seg;
  logic [NUM_DIGITS-1:0] anode_nxt;
  seg_t                  cathode_nxt;
  logic                  dp_nxt;

  assign refresh_tc = (refresh_cnt == REF_TC);
  assign frame_wrap = refresh_tc && (digit_idx == IDX_LAST);

  // sub_cnt tracks refresh_cnt / SLOT without a divider: a down-counter
  // paces each PWM sub-slot.
  assign pwm_on      = (sub_cnt <= brightness);
  assign visible     = display_On && !shadow_blank[digit_idx]
                       && !(shadow_blink[digit_idx] && blink_off) && pwm_on;
  assign ghost_guard = (refresh_cnt == '0) && !((&brightness) && NO_GUARD_DIV);
  assign cur_hex     = shadow_digits[4*int'(digit_idx) +: 4];

  hex_seg_decode u_decode (
    .hex (cur_hex),
    .seg (cur_seg)
  );

  always_comb begin
    anode_nxt   = '1;
    cathode_nxt = SEG_BLANK;
    dp_nxt      = 1'b1;
    if (visible) begin
      cathode_nxt = cur_seg;
      dp_nxt      = ~shadow_dp[digit_idx];
      if (!ghost_guard) anode_nxt[digit_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      refresh_cnt   <= '0;
      slot_cnt      <= SLOT_LOAD;
      sub_cnt       <= '0;
      digit_idx     <= '0;
      blink_cnt     <= '0;
      blink_off     <= 1'b0;
      shadow_digits <= '0;
      shadow_dp     <= '0;
      shadow_blank  <= '0;
      shadow_blink  <= '0;
      anode         <= '1;
      cathode       <= SEG_BLANK;
      svn_Seg_Dot   <= 1'b1;
      frame_tick    <= 1'b0;
    end else begin
      if (refresh_tc) begin
        refresh_cnt <= '0;
        slot_cnt    <= SLOT_LOAD;
        sub_cnt     <= '0;
        digit_idx   <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
        if (slot_cnt == '0) begin
          slot_cnt <= SLOT_LOAD;
          sub_cnt  <= sub_cnt + 1'b1;
        end else begin
          slot_cnt <= slot_cnt - 1'b1;
        end
      end

      if (frame_wrap) begin
        shadow_digits <= digits_in;
        shadow_dp     <= dp_in;
        shadow_blank  <= blank_mask;
        shadow_blink  <= blink_mask;
        if (blink_cnt == BLINK_TC) begin
          blink_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      anode       <= anode_nxt;
      cathode     <= cathode_nxt;
      svn_Seg_Dot <= dp_nxt;
      frame_tick  <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench: cycle-by-cycle comparison against a time-indexed model.
module tb_display_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int PB  = 2;
  localparam int BF  = 2;
  localparam int FRAME = DIV * N;

  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [15:0]   digits_in = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    blank_mask = '0;
  logic [3:0]    blink_mask = '0;
  logic          display_On = 1'b0;
  logic [PB-1:0] brightness = '0;
  logic [6:0]    cathode;
  logic          svn_Seg_Dot;
  logic [3:0]    anode;
  logic          frame_tick;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Model: t = clock edges since reset released; latched inputs per frame.
  int          t = 0;
  logic [15:0] l_dig = '0;
  logic [3:0]  l_dp = '0, l_blank = '0, l_blink = '0;

  display_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(DIV), .PWM_BITS(PB), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .digits_in(digits_in), .dp_in(dp_in),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .display_On(display_On),
    .brightness(brightness), .cathode(cathode), .svn_Seg_Dot(svn_Seg_Dot),
    .anode(anode), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [3:0] ea;
    logic [6:0] ec;
    logic       ed, et, boff, vis, guard;
    int         r, d, f, sub;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      t = 0;
      l_dig = '0; l_dp = '0; l_blank = '0; l_blink = '0;
      ea = 4'hF; ec = 7'h7F; ed = 1'b1; et = 1'b0;
    end else begin
      r    = t % DIV;
      d    = (t / DIV) % N;
      f    = t / FRAME;
      sub  = r / (DIV >> PB);
      boff = ((f / BF) % 2) == 1;
      vis  = display_On && !l_blank[d] && !(l_blink[d] && boff) && (sub <= int'(brightness));
      guard = (r == 0) && !((brightness == '1) && (DIV == (1 << PB)));
      ea = 4'hF;
      if (vis && !guard) ea[d] = 1'b0;
      ec = vis ? SEG[l_dig[4*d +: 4]] : 7'h7F;
      ed = vis ? ~l_dp[d] : 1'b1;
      t++;
      et = (t % FRAME) == 0;
      if (et) begin
        l_dig = digits_in; l_dp = dp_in; l_blank = blank_mask; l_blink = blink_mask;
      end
    end
    chk("anode",      32'(anode),       32'(ea));
    chk("cathode",    32'(cathode),     32'(ec));
    chk("dp",         32'(svn_Seg_Dot), 32'(ed));
    chk("frame_tick", 32'(frame_tick),  32'(et));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // 1. reset then plain scan
    reset_n = 1'b0;
    run(2);
    digits_in = 16'h1234; brightness = 2'd3; display_On = 1'b1; reset_n = 1'b1;
    run(3 * FRAME);
    // 2. mid-frame digit change
    run(13);
    digits_in = 16'hABCD;
    run(2 * FRAME);
    // 3. minimum brightness
    brightness = 2'd0;
    run(2 * FRAME);
    brightness = 2'd3;
    // 4. blink and blank
    blink_mask = 4'b0001; blank_mask = 4'b0100;
    run(8 * FRAME);
    blink_mask = '0; blank_mask = '0;
    // 5. decimal point and display enable
    dp_in = 4'b0001;
    run(2 * FRAME);
    display_On = 1'b0;
    run(21);
    display_On = 1'b1;
    run(2 * FRAME);
    // 6. reset mid-frame at digit 2, sub 1
    for (int i = 0; i < FRAME && (t % FRAME) != 2 * DIV + 2; i++) cycle();
    chk("reset_align", 32'(t % FRAME), 32'(2 * DIV + 2));
    reset_n = 1'b0;
    run(1);
    reset_n = 1'b1;
    run(2 * FRAME);
    // 7. randomized inputs
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) digits_in = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_mask = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) brightness = PB'($urandom);
      if ($urandom_range(0, 63) == 0) display_On = ~display_On;
      reset_n = ($urandom_range(0, 399) != 0);
      cycle();
    end
    reset_n = 1'b1;
    run(FRAME);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
